tof_i2c_arbiter: RTL
====================

Name: tof_i2c_arbiter

Overview:
- Shares the single I2C transaction master among NUM_REQ ToF sensor sequencers (one per sensor).
- Each requester drives the same start/ready transaction interface it would drive into a dedicated master.
- The arbiter grants the bus round-robin and holds the grant for the whole transaction, including multi-byte firmware bursts.
- It routes the handshake back to the owner only and enforces a watchdog timeout, so a hung sensor cannot starve the others.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1000000, max cycles in BUSY without an m_ready rising edge before abort
TMR_W, 20, watchdog counter width (must satisfy 2**TMR_W > TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_start  in  NUM_REQ  per-requester transaction request (level, held until the requester releases it)
req_is_read  in  NUM_REQ  per-requester read/write select
req_register_address  in  16*NUM_REQ  packed register addresses; requester i is at [16i+15:16i]
req_i2c_data  in  8*NUM_REQ  packed write bytes
req_nb_of_bytes  in  17*NUM_REQ  packed burst lengths
req_ready  out  NUM_REQ  registered m_ready, routed to the owner only
req_error  out  NUM_REQ  registered m_error or timeout pulse, routed to the owner only
req_i2c_data_in  out  16  registered m_i2c_data_in, broadcast to all requesters
grant  out  NUM_REQ  one-hot current owner; 0 when idle
m_start  out  1  start to the I2C master
m_is_read  out  1  muxed is_read
m_register_address  out  16  muxed address
m_i2c_data  out  8  muxed write data
m_nb_of_bytes  out  17  muxed burst length
m_ready  in  1  I2C master transaction/byte done
m_error  in  1  I2C master error (NACK etc.)
m_i2c_data_in  in  16  I2C master read data
busy  out  1  high in GRANT, BUSY and DRAIN
timeout_count  out  8  saturating count of watchdog aborts

Behaviour:
- Reset (reset=0, async): all outputs 0; state=IDLE; rr_ptr=0; timer=0. m_start falls immediately, even mid-transaction.
- All outputs are registered.
- State IDLE:
  - Waits for |req_start and m_ready==0.
  - Selects the first asserted index scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
  - Latches owner, sets grant[owner], sets rr_ptr = (owner+1) mod NUM_REQ, then goes to GRANT.
  - A request that drops before selection is ignored.
- State GRANT (exactly 1 cycle):
  - Registers the owner's is_read/address/data/nb_of_bytes onto the m_* outputs.
  - m_start stays 0 this cycle so the payload is stable one cycle before start.
  - Clears timer; goes to BUSY.
- State BUSY:
  - m_start <= req_start[owner], so it tracks the owner with 1-cycle latency.
  - The m_* payload is re-registered from the owner every cycle, which allows streaming bursts where the requester updates data/address per byte.
  - req_ready[owner] <= m_ready; req_error[owner] <= m_error. All other req_ready/req_error bits are 0.
  - req_i2c_data_in <= m_i2c_data_in every cycle.
  - timer increments each cycle and clears on an m_ready rising edge.
  - When req_start[owner]==0: m_start <= 0, go to DRAIN.
  - When timer==TIMEOUT_CYCLES-1: req_error[owner] pulses high 1 cycle, m_start <= 0, timeout_count increments (saturates at 255), go to DRAIN.
  - A timeout takes precedence over a simultaneous req_start drop; the pulse still fires.
- State DRAIN:
  - m_start=0.
  - Stays until m_ready==0 (minimum 1 cycle).
  - Then clears grant and goes to IDLE.
  - No new grant is issued in the DRAIN exit cycle. Minimum back-to-back gap between transactions is IDLE + GRANT = 2 cycles after DRAIN.
  - While in DRAIN, req_ready/req_error for the old owner are forced to 0.
- Fairness: any requester holding req_start is granted within NUM_REQ-1 other transactions.
- A requester that re-asserts immediately after release goes behind the others.
- Payload/is_read changes of non-owners have no effect.
- State encoding is free; an illegal state recovers to IDLE with grant=0 and m_start=0.

Test Plan:
- Single requester: req_start[2]=1, addr 16'h7FFF, data 8'h00. Expect grant=4'b0100; m_register_address=16'h7FFF one cycle before m_start=1. Then m_ready=1 → req_ready[2]=1 next cycle. Drop req_start → m_start=0, then drop m_ready → grant=0 and busy=0.
- Round-robin: all four req_start held continuously, each completing one transaction. Grant order must be 0,1,2,3,0 with no owner repeated before the other three.
- Burst of 5 bytes from req 1: nb_of_bytes=17'h5, address/data updated after each m_ready pulse. Expect all 5 values on m_*. Requests from req 0 and req 3 raised mid-burst must not be granted until req 1 drops start.
- Timeout: TIMEOUT_CYCLES=16, m_ready held 0. Expect req_error[owner] single pulse on the 16th BUSY cycle, m_start=0, timeout_count=1, then the next requester is granted.
- Error routing: m_error=1 during req 3 transaction. Expect req_error=4'b1000 and req_error[0..2]=0.
- Async reset mid-burst: reset=0 between clock edges. Expect m_start=0 and grant=0 immediately. After release, the first grant goes to req 0 (rr_ptr reset).

Source files
------------

// File: rtl/tof_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C transaction master among NUM_REQ ToF sequencers.
// The grant is held for a whole transaction, and a watchdog aborts owners that stop responding.
module tof_i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TMR_W          = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_start,
  input  logic [NUM_REQ-1:0]    req_is_read,
  input  logic [16*NUM_REQ-1:0] req_register_address,
  input  logic [8*NUM_REQ-1:0]  req_i2c_data,
  input  logic [17*NUM_REQ-1:0] req_nb_of_bytes,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    req_error,
  output logic [15:0]           req_i2c_data_in,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  m_start,
  output logic                  m_is_read,
  output logic [15:0]           m_register_address,
  output logic [7:0]            m_i2c_data,
  output logic [16:0]           m_nb_of_bytes,
  input  logic                  m_ready,
  input  logic                  m_error,
  input  logic [15:0]           m_i2c_data_in,
  output logic                  busy,
  output logic [7:0]            timeout_count
);

  // state   | meaning
  // S_IDLE  | no owner; picks the next requester round-robin from rr_ptr
  // S_GRANT | owner latched, payload registered, m_start still low
  // S_BUSY  | transaction running; handshake routed to owner, watchdog counting
  // S_DRAIN | owner released or timed out; wait for m_ready low before freeing the bus
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_DRAIN} state_t;

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [TMR_W-1:0]   timer;
  logic               m_ready_q;

  logic [15:0]        addr_arr [NUM_REQ];
  logic [7:0]         data_arr [NUM_REQ];
  logic [16:0]        nb_arr   [NUM_REQ];

  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   nxt_ptr;
  logic [NUM_REQ-1:0] sel_onehot;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_register_address[16*i +: 16];
      data_arr[i] = req_i2c_data[8*i +: 8];
      nb_arr[i]   = req_nb_of_bytes[17*i +: 17];
    end
  end

  // First asserted request scanning from rr_ptr upward, wrapping at NUM_REQ.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    found      = 1'b0;
    cand       = '0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_start[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
    sel_onehot[sel_idx] = 1'b1;
    nxt_ptr = (int'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      rr_ptr             <= '0;
      owner              <= '0;
      timer              <= '0;
      m_ready_q          <= 1'b0;
      req_ready          <= '0;
      req_error          <= '0;
      req_i2c_data_in    <= '0;
      grant              <= '0;
      m_start            <= 1'b0;
      m_is_read          <= 1'b0;
      m_register_address <= '0;
      m_i2c_data         <= '0;
      m_nb_of_bytes      <= '0;
      busy               <= 1'b0;
      timeout_count      <= '0;
    end else begin
      m_ready_q <= m_ready;
      case (state)
        S_IDLE: begin
          m_start   <= 1'b0;
          req_ready <= '0;
          req_error <= '0;
          if (|req_start && !m_ready) begin
            owner  <= sel_idx;
            grant  <= sel_onehot;
            rr_ptr <= nxt_ptr;
            busy   <= 1'b1;
            state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          m_is_read          <= req_is_read[owner];
          m_register_address <= addr_arr[owner];
          m_i2c_data         <= data_arr[owner];
          m_nb_of_bytes      <= nb_arr[owner];
          timer              <= '0;
          state              <= S_BUSY;
        end
        S_BUSY: begin
          // Payload follows the owner every cycle so streaming bursts can update per byte.
          m_is_read          <= req_is_read[owner];
          m_register_address <= addr_arr[owner];
          m_i2c_data         <= data_arr[owner];
          m_nb_of_bytes      <= nb_arr[owner];
          req_i2c_data_in    <= m_i2c_data_in;
          if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            m_start   <= 1'b0;
            req_ready <= '0;
            req_error <= grant;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 1'b1;
            state     <= S_DRAIN;
          end else if (!req_start[owner]) begin
            m_start   <= 1'b0;
            req_ready <= '0;
            req_error <= '0;
            state     <= S_DRAIN;
          end else begin
            m_start   <= 1'b1;
            req_ready <= grant & {NUM_REQ{m_ready}};
            req_error <= grant & {NUM_REQ{m_error}};
            timer     <= (m_ready && !m_ready_q) ? '0 : timer + 1'b1;
          end
        end
        S_DRAIN: begin
          m_start   <= 1'b0;
          req_ready <= '0;
          req_error <= '0;
          if (!m_ready) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          m_start   <= 1'b0;
          req_ready <= '0;
          req_error <= '0;
          grant     <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
